// File: rtl/cpu_mem_pkg.sv
// Shared types and encodings for the MEM-stage load/store unit.
package cpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_MEM = 2'd0;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Lane steering: byte enables and write-data replication for stores, lane
// extraction plus sign/zero extension for loads, and alignment checking.
module lsu_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_ext,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_uns;

  always_comb begin
    o_be         = 4'h0;
    o_wdata      = '0;
    o_ld_ext     = '0;
    o_misaligned = 1'b0;
    w_byte       = i_rdata[{i_off, 3'b000} +: 8];
    w_half       = i_rdata[{i_off[1], 4'b0000} +: 16];
    w_uns        = i_funct3[2];
    case (i_funct3[1:0])
      F3_B[1:0]: begin
        o_be     = 4'b0001 << i_off;
        o_wdata  = {4{i_rs2[7:0]}};
        o_ld_ext = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      F3_H[1:0]: begin
        o_be         = 4'b0011 << {i_off[1], 1'b0};
        o_wdata      = {2{i_rs2[15:0]}};
        o_ld_ext     = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        o_misaligned = i_off[0];
      end
      // Both 2'b10 and 2'b11 are word accesses; extension is moot at full width.
      default: begin
        o_be         = 4'hF;
        o_wdata      = i_rs2;
        o_ld_ext     = i_rdata;
        o_misaligned = |i_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory handshake, holds the
// pipeline until the access completes and returns the extended load result.
module mem_stage_lsu
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           instr_MEM,
  input  logic [31:0]           aludata_MEM,
  input  logic [31:0]           rs2data_MEM,
  input  logic                  MemRW_MEM,
  input  logic [1:0]            WBSel_MEM,
  mem_stage_lsu_if.master       dmem,
  output logic [31:0]           lddata_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;

  logic        w_mem_op;
  logic        w_go;
  logic        w_timeout;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_ext;
  logic        w_unused_instr;

  assign w_unused_instr = ^{instr_MEM[31:15], instr_MEM[11:0]};
  assign w_mem_op       = MemRW_MEM | (WBSel_MEM == WB_MEM);
  assign w_go           = w_mem_op & ~w_mis;
  assign w_timeout      = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // EX/MEM is frozen while stalled, so the live inputs still describe the
  // access in flight and can steer load extraction when rvalid arrives.
  lsu_align u_align (
    .i_off        (aludata_MEM[1:0]),
    .i_funct3     (instr_MEM[14:12]),
    .i_rs2        (rs2data_MEM),
    .i_rdata      (dmem.rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ld_ext     (w_ld_ext),
    .o_misaligned (w_mis)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    stall_o    = w_go & (r_state != DONE);
    misalign_o = w_mem_op & w_mis;
    unique case (r_state)
      IDLE:    if (w_go) w_next = REQ;
      REQ:     if (dmem.gnt) w_next = dmem.we ? DONE : WAIT;
      WAIT:    if (dmem.rvalid || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= 4'h0;
      dmem.wdata <= '0;
      lddata_o   <= '0;
      bus_err_o  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          dmem.req   <= 1'b1;
          dmem.we    <= MemRW_MEM;
          dmem.addr  <= {aludata_MEM[31:2], 2'b00};
          dmem.be    <= w_be;
          dmem.wdata <= w_wdata;
        end
        REQ: if (dmem.gnt) begin
          dmem.req <= 1'b0;
          r_cnt    <= '0;
        end
        // rvalid wins over a timeout landing in the same cycle.
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (dmem.rvalid) begin
            lddata_o <= w_ld_ext;
          end else if (w_timeout) begin
            lddata_o  <= '0;
            bus_err_o <= 1'b1;
          end
        end
        DONE: bus_err_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus randomized ops against a
// behavioural model of lanes, extension, handshake latency and timeout.
module tb_mem_stage_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr, alu, rs2;
  logic        memrw;
  logic [1:0]  wbsel;
  logic [31:0] lddata;
  logic        stall, mis, berr;
  logic [31:0] exp_ld_reg;
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_stage_lsu_if dmem ();

  mem_stage_lsu #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .instr_MEM   (instr),
    .aludata_MEM (alu),
    .rs2data_MEM (rs2),
    .MemRW_MEM   (memrw),
    .WBSel_MEM   (wbsel),
    .dmem        (dmem),
    .lddata_o    (lddata),
    .stall_o     (stall),
    .misalign_o  (mis),
    .bus_err_o   (berr)
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic exp_mis(input logic [2:0] f3, input logic [1:0] off);
    return (int'(off) % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    int sz, lane;
    logic [3:0] b;
    sz = size_of(f3);
    lane = int'(off) - (int'(off) % sz);
    b = 4'h0;
    for (int i = 0; i < sz; i++) b[lane + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    logic [31:0] w;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    int sz, lane;
    logic [31:0] v, mask;
    sz = size_of(f3);
    lane = int'(off) - (int'(off) % sz);
    v = rd >> (8 * lane);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = v & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // kind: 0 store, 1 load, 2 non-memory. gd = REQ cycles before gnt,
  // rd = WAIT cycles before rvalid (>= TO means never).
  task automatic run_op(input string nm, input int kind, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int gd, input int rd, input logic [31:0] rdat);
    logic mem, misx, ld_op, granted, done;
    int exp_st, cyc, stalls, reqs, waits, req_first;
    mem   = (kind != 2);
    ld_op = (kind == 1);
    misx  = mem && exp_mis(f3, a[1:0]);
    if (!mem || misx) exp_st = 0;
    else if (!ld_op)  exp_st = gd + 2;
    else              exp_st = gd + 2 + ((rd < TO) ? rd + 1 : TO);
    @(negedge clk);
    instr = $urandom;
    instr[14:12] = f3;
    alu = a;
    rs2 = d;
    memrw = (kind == 0);
    if (kind == 0)      wbsel = 2'($urandom_range(0, 3));
    else if (kind == 1) wbsel = 2'd0;
    else                wbsel = 2'($urandom_range(1, 3));
    dmem.gnt = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata = $urandom;
    cyc = 0; stalls = 0; reqs = 0; waits = 0; req_first = -1;
    granted = 1'b0; done = 1'b0;
    while (!done && cyc < 200) begin
      #1;
      if (stall) begin
        stalls++;
        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata = $urandom;
        if (dmem.req) begin
          if (req_first < 0) req_first = cyc;
          n_cmp++;
          if (dmem.we !== !ld_op || dmem.addr !== {a[31:2], 2'b00} || dmem.be !== exp_be(f3, a[1:0])) begin
            n_bad++;
            $display("FAIL %s req: we/addr/be got %b/%h/%b want %b/%h/%b", nm, dmem.we, dmem.addr,
                     dmem.be, !ld_op, {a[31:2], 2'b00}, exp_be(f3, a[1:0]));
          end
          if (!ld_op) begin
            n_cmp++;
            if (dmem.wdata !== exp_wd(f3, d)) begin
              n_bad++;
              $display("FAIL %s wdata: got %h want %h", nm, dmem.wdata, exp_wd(f3, d));
            end
          end
          reqs++;
          if (reqs - 1 == gd) begin dmem.gnt = 1'b1; granted = 1'b1; end
        end else if (granted) begin
          waits++;
          if (waits - 1 == rd) begin dmem.rvalid = 1'b1; dmem.rdata = rdat; end
        end
        @(negedge clk);
        cyc++;
      end else begin
        done = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s done: stall still high after %0d cycles, want low", nm, cyc); end
    n_cmp++;
    if (stalls != exp_st) begin n_bad++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, exp_st); end
    n_cmp++;
    if (mis !== misx) begin n_bad++; $display("FAIL %s misalign: got %b want %b", nm, mis, misx); end
    if (mem && !misx) begin
      n_cmp++;
      if (req_first != 1) begin n_bad++; $display("FAIL %s req_start: got cycle %0d want 1", nm, req_first); end
      n_cmp++;
      if (dmem.req !== 1'b0) begin n_bad++; $display("FAIL %s req_in_done: got %b want 0", nm, dmem.req); end
      if (ld_op) exp_ld_reg = (rd < TO) ? exp_ld(f3, a[1:0], rdat) : 32'h0;
      n_cmp++;
      if (berr !== (ld_op && rd >= TO)) begin
        n_bad++; $display("FAIL %s bus_err: got %b want %b", nm, berr, (ld_op && rd >= TO));
      end
    end else begin
      n_cmp++;
      if (berr !== 1'b0) begin n_bad++; $display("FAIL %s bus_err: got %b want 0", nm, berr); end
    end
    n_cmp++;
    if (lddata !== exp_ld_reg) begin n_bad++; $display("FAIL %s lddata: got %h want %h", nm, lddata, exp_ld_reg); end
    // Stray handshake pulses in DONE/IDLE must be ignored.
    dmem.gnt = 1'($urandom);
    dmem.rvalid = 1'($urandom);
    if (!mem || misx) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (dmem.req !== 1'b0 || stall !== 1'b0 || lddata !== exp_ld_reg) begin
        n_bad++;
        $display("FAIL %s hold: req/stall/lddata got %b/%b/%h want 0/0/%h", nm, dmem.req, stall, lddata, exp_ld_reg);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata, lddata, berr, stall, mis} !== '0) begin
      n_bad++;
      $display("FAIL reset: req/we/addr/be/wdata/lddata/berr/stall/mis got %b/%b/%h/%b/%h/%h/%b/%b/%b want all 0",
               dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata, lddata, berr, stall, mis);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sb;
    run_op("sb", 0, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 0, 0, 32'h0);
    n_cmp++;
    if (dmem.addr !== 32'h100 || dmem.be !== 4'b1000 || dmem.wdata !== 32'hDDDD_DDDD) begin
      n_bad++;
      $display("FAIL sb_bus: addr/be/wdata got %h/%b/%h want 00000100/1000/dddddddd", dmem.addr, dmem.be, dmem.wdata);
    end
  endtask

  task automatic test_lb;
    run_op("lb", 1, 3'b000, 32'h0000_0202, 32'h0, 3, 0, 32'h12F4_5678);
    n_cmp++;
    if (lddata !== 32'hFFFF_FFF4) begin n_bad++; $display("FAIL lb_value: got %h want fffffff4", lddata); end
    run_op("lbu", 1, 3'b100, 32'h0000_0202, 32'h0, 3, 0, 32'h12F4_5678);
    n_cmp++;
    if (lddata !== 32'h0000_00F4) begin n_bad++; $display("FAIL lbu_value: got %h want 000000f4", lddata); end
  endtask

  task automatic test_misalign;
    run_op("lh_mis", 1, 3'b001, 32'h0000_0001, 32'h0, 0, 0, 32'h0);
    run_op("sw_mis", 0, 3'b010, 32'h0000_0012, 32'h1234_5678, 0, 0, 32'h0);
  endtask

  task automatic test_reset_wait;
    @(negedge clk);
    instr = 32'h0; instr[14:12] = 3'b010; alu = 32'h40; memrw = 1'b0; wbsel = 2'd0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (dmem.req !== 1'b1) begin n_bad++; $display("FAIL rstwait_req: got %b want 1", dmem.req); end
    dmem.gnt = 1'b1;
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1 || dmem.req !== 1'b0) begin
      n_bad++; $display("FAIL rstwait_wait: stall/req got %b/%b want 1/0", stall, dmem.req);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lddata !== 32'h0 || dmem.req !== 1'b0 || berr !== 1'b0 || dmem.addr !== 32'h0) begin
      n_bad++; $display("FAIL rstwait_reset: lddata/req/berr/addr got %h/%b/%b/%h want 0", lddata, dmem.req, berr, dmem.addr);
    end
    memrw = 1'b0; wbsel = 2'd1; dmem.rvalid = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem.rvalid = 1'b0;
    #1;
    exp_ld_reg = 32'h0;
    n_cmp++;
    if (lddata !== 32'h0 || dmem.req !== 1'b0 || stall !== 1'b0) begin
      n_bad++; $display("FAIL rstwait_after: lddata/req/stall got %h/%b/%b want 0/0/0", lddata, dmem.req, stall);
    end
  endtask

  task automatic test_timeout;
    run_op("lw_timeout", 1, 3'b010, 32'h0000_0080, 32'h0, 1, TO + 5, 32'h0);
    @(negedge clk);
    memrw = 1'b0; wbsel = 2'd1; dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    #1;
    n_cmp++;
    if (berr !== 1'b0 || stall !== 1'b0 || lddata !== 32'h0) begin
      n_bad++; $display("FAIL timeout_after: berr/stall/lddata got %b/%b/%h want 0/0/0", berr, stall, lddata);
    end
  endtask

  task automatic test_back_to_back;
    run_op("b2b_sw", 0, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 1, 0, 32'h0);
    run_op("b2b_lw", 1, 3'b010, 32'h0000_0304, 32'h0, 0, 1, 32'h8765_4321);
    run_op("b2b_lh", 1, 3'b001, 32'h0000_0306, 32'h0, 2, 0, 32'h8001_7FFF);
  endtask

  task automatic test_random;
    int kind, gd, rd;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      gd   = $urandom_range(0, 3);
      rd   = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, 3);
      run_op("rand", kind, 3'($urandom_range(0, 7)), $urandom, $urandom, gd, rd, $urandom);
    end
  endtask

  initial begin
    instr = 32'h0; alu = 32'h0; rs2 = 32'h0; memrw = 1'b0; wbsel = 2'd1;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'h0;
    exp_ld_reg = 32'h0;
    test_reset;
    test_sb;
    test_lb;
    test_misalign;
    test_reset_wait;
    test_timeout;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
